// File: rtl/rf_port_arbiter_pkg.sv
// Shared definitions for the register-file port arbiter: address width, default
// data width, requester indices and the read-pending record.
package rf_port_arbiter_pkg;

  localparam int REG_AW     = 5;
  localparam int DW_DEFAULT = 32;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic valid;
    logic owner;
    logic fwd_a;
    logic fwd_b;
  } rd_pend_t;

  // The register file drops writes to r0, so those never forward.
  function automatic logic fwd_hit(input logic wr_gnt, input reg_addr_t rw, input reg_addr_t ra);
    return wr_gnt && (rw != {REG_AW{1'b0}}) && (rw == ra);
  endfunction

endpackage

// File: rtl/rf_port_arbiter_rr_arb2.sv
// Two-input arbiter with a last-grant pointer: round-robin when RR_EN is set,
// otherwise fixed priority to input 0. No grants while rst is high.
module rf_port_arbiter_rr_arb2
  import rf_port_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_r;

  // Grant selection; on contention the requester not served last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else if (req0 && req1) begin
      if (RR_EN) begin
        gnt0 = last_r;
        gnt1 = ~last_r;
      end else begin
        gnt0 = 1'b1;
        gnt1 = 1'b0;
      end
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  // Last-grant pointer, reset to requester 1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= REQ_DBG;
    end else if (gnt0 || gnt1) begin
      last_r <= gnt1;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares the register file's read and write ports between the core controller
// and the debug unit, with same-cycle write forwarding into read responses.
module rf_port_arbiter
  import rf_port_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1,
  parameter int DW    = DW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_0,
  input  logic              cmd_valid_1,
  output logic              cmd_ready_0,
  output logic              cmd_ready_1,
  input  logic              cmd_we_0,
  input  logic              cmd_we_1,
  input  logic [REG_AW-1:0] cmd_ra_0,
  input  logic [REG_AW-1:0] cmd_ra_1,
  input  logic [REG_AW-1:0] cmd_rb_0,
  input  logic [REG_AW-1:0] cmd_rb_1,
  input  logic [REG_AW-1:0] cmd_rw_0,
  input  logic [REG_AW-1:0] cmd_rw_1,
  input  logic [DW-1:0]     cmd_wdata_0,
  input  logic [DW-1:0]     cmd_wdata_1,
  output logic              rsp_valid_0,
  output logic              rsp_valid_1,
  output logic [DW-1:0]     rsp_a_0,
  output logic [DW-1:0]     rsp_a_1,
  output logic [DW-1:0]     rsp_b_0,
  output logic [DW-1:0]     rsp_b_1,
  output logic [REG_AW-1:0] rf_ra,
  output logic [REG_AW-1:0] rf_rb,
  output logic [REG_AW-1:0] rf_rw,
  output logic [DW-1:0]     rf_busw,
  output logic              rf_regwr,
  input  logic [DW-1:0]     rf_busa,
  input  logic [DW-1:0]     rf_busb
);

  logic rd_req0_s, rd_req1_s, wr_req0_s, wr_req1_s;
  logic rd_gnt0_s, rd_gnt1_s, wr_gnt0_s, wr_gnt1_s;
  rd_pend_t pend_r;
  logic [DW-1:0] wdata_r;
  logic [DW-1:0] data_a_s, data_b_s;
  logic [DW-1:0] rsp_a0_r, rsp_b0_r, rsp_a1_r, rsp_b1_r;

  assign rd_req0_s = cmd_valid_0 & ~cmd_we_0;
  assign rd_req1_s = cmd_valid_1 & ~cmd_we_1;
  assign wr_req0_s = cmd_valid_0 &  cmd_we_0;
  assign wr_req1_s = cmd_valid_1 &  cmd_we_1;

  rf_port_arbiter_rr_arb2 #(.RR_EN(RR_EN)) u_rd_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (rd_req0_s),
    .req1 (rd_req1_s),
    .gnt0 (rd_gnt0_s),
    .gnt1 (rd_gnt1_s)
  );

  rf_port_arbiter_rr_arb2 #(.RR_EN(RR_EN)) u_wr_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (wr_req0_s),
    .req1 (wr_req1_s),
    .gnt0 (wr_gnt0_s),
    .gnt1 (wr_gnt1_s)
  );

  assign cmd_ready_0 = rd_gnt0_s | wr_gnt0_s;
  assign cmd_ready_1 = rd_gnt1_s | wr_gnt1_s;

  // Register file read-port mux; idle ports park at address 0.
  always_comb begin
    rf_ra = {REG_AW{1'b0}};
    rf_rb = {REG_AW{1'b0}};
    if (rd_gnt0_s) begin
      rf_ra = cmd_ra_0;
      rf_rb = cmd_rb_0;
    end else if (rd_gnt1_s) begin
      rf_ra = cmd_ra_1;
      rf_rb = cmd_rb_1;
    end else begin
      rf_ra = {REG_AW{1'b0}};
      rf_rb = {REG_AW{1'b0}};
    end
  end

  // Register file write-port mux.
  always_comb begin
    rf_rw    = {REG_AW{1'b0}};
    rf_busw  = {DW{1'b0}};
    rf_regwr = 1'b0;
    if (wr_gnt0_s) begin
      rf_rw    = cmd_rw_0;
      rf_busw  = cmd_wdata_0;
      rf_regwr = 1'b1;
    end else if (wr_gnt1_s) begin
      rf_rw    = cmd_rw_1;
      rf_busw  = cmd_wdata_1;
      rf_regwr = 1'b1;
    end else begin
      rf_rw    = {REG_AW{1'b0}};
      rf_busw  = {DW{1'b0}};
      rf_regwr = 1'b0;
    end
  end

  // Pending read: owner, forwarding flags and the coincident write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r  <= '{1'b0, 1'b0, 1'b0, 1'b0};
      wdata_r <= {DW{1'b0}};
    end else begin
      pend_r.valid <= rd_gnt0_s | rd_gnt1_s;
      pend_r.owner <= rd_gnt1_s;
      pend_r.fwd_a <= fwd_hit(rf_regwr, rf_rw, rf_ra);
      pend_r.fwd_b <= fwd_hit(rf_regwr, rf_rw, rf_rb);
      wdata_r      <= rf_busw;
    end
  end

  // The register file shows the pre-write value, so a coincident write wins here.
  assign data_a_s    = pend_r.fwd_a ? wdata_r : rf_busa;
  assign data_b_s    = pend_r.fwd_b ? wdata_r : rf_busb;
  assign rsp_valid_0 = pend_r.valid & (pend_r.owner == REQ_CORE) & ~rst;
  assign rsp_valid_1 = pend_r.valid & (pend_r.owner == REQ_DBG)  & ~rst;

  // Last delivered response per requester, shown while that requester is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_a0_r <= {DW{1'b0}};
      rsp_b0_r <= {DW{1'b0}};
      rsp_a1_r <= {DW{1'b0}};
      rsp_b1_r <= {DW{1'b0}};
    end else if (rsp_valid_0) begin
      rsp_a0_r <= data_a_s;
      rsp_b0_r <= data_b_s;
    end else if (rsp_valid_1) begin
      rsp_a1_r <= data_a_s;
      rsp_b1_r <= data_b_s;
    end else begin
      rsp_a0_r <= rsp_a0_r;
      rsp_b0_r <= rsp_b0_r;
      rsp_a1_r <= rsp_a1_r;
      rsp_b1_r <= rsp_b1_r;
    end
  end

  // Response routing to the owning requester.
  always_comb begin
    rsp_a_0 = rsp_a0_r;
    rsp_b_0 = rsp_b0_r;
    rsp_a_1 = rsp_a1_r;
    rsp_b_1 = rsp_b1_r;
    if (rsp_valid_0) begin
      rsp_a_0 = data_a_s;
      rsp_b_0 = data_b_s;
    end else if (rsp_valid_1) begin
      rsp_a_1 = data_a_s;
      rsp_b_1 = data_b_s;
    end else begin
      rsp_a_0 = rsp_a0_r;
      rsp_b_0 = rsp_b0_r;
    end
  end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: a round-robin and a fixed-priority instance, each with
// its own registered register-file model, checked against a register-level reference.
module tb_rf_port_arbiter;
  import rf_port_arbiter_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    bit          v;
    bit          we;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rw;
    logic [W-1:0] wd;
  } cmd_t;

  typedef struct packed {
    bit           rst;
    cmd_t         c0;
    cmd_t         c1;
    bit           e_rdy0;
    bit           e_rdy1;
    bit           e_rv0;
    bit           e_rv1;
    logic [W-1:0] e_a;
    logic [W-1:0] e_b;
    bit           f_rdy0;
    bit           f_rdy1;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic v0, we0, v1, we1;
  logic [4:0] ra0, rb0, rw0, ra1, rb1, rw1;
  logic [W-1:0] wd0, wd1;

  logic [1:0] rdy0, rdy1, rv0, rv1, regwr;
  logic [4:0] rfa [2];
  logic [4:0] rfb [2];
  logic [4:0] rfw [2];
  logic [W-1:0] busw [2];
  logic [W-1:0] busa [2];
  logic [W-1:0] busb [2];
  logic [W-1:0] a0 [2];
  logic [W-1:0] b0 [2];
  logic [W-1:0] a1 [2];
  logic [W-1:0] b1 [2];
  logic [W-1:0] rfmem [2][32];

  rf_port_arbiter #(.RR_EN(1'b1), .DW(W)) dut_rr (
    .clk(clk), .rst(rst),
    .cmd_valid_0(v0), .cmd_valid_1(v1), .cmd_ready_0(rdy0[0]), .cmd_ready_1(rdy1[0]),
    .cmd_we_0(we0), .cmd_we_1(we1), .cmd_ra_0(ra0), .cmd_ra_1(ra1),
    .cmd_rb_0(rb0), .cmd_rb_1(rb1), .cmd_rw_0(rw0), .cmd_rw_1(rw1),
    .cmd_wdata_0(wd0), .cmd_wdata_1(wd1),
    .rsp_valid_0(rv0[0]), .rsp_valid_1(rv1[0]),
    .rsp_a_0(a0[0]), .rsp_a_1(a1[0]), .rsp_b_0(b0[0]), .rsp_b_1(b1[0]),
    .rf_ra(rfa[0]), .rf_rb(rfb[0]), .rf_rw(rfw[0]), .rf_busw(busw[0]),
    .rf_regwr(regwr[0]), .rf_busa(busa[0]), .rf_busb(busb[0])
  );

  rf_port_arbiter #(.RR_EN(1'b0), .DW(W)) dut_fp (
    .clk(clk), .rst(rst),
    .cmd_valid_0(v0), .cmd_valid_1(v1), .cmd_ready_0(rdy0[1]), .cmd_ready_1(rdy1[1]),
    .cmd_we_0(we0), .cmd_we_1(we1), .cmd_ra_0(ra0), .cmd_ra_1(ra1),
    .cmd_rb_0(rb0), .cmd_rb_1(rb1), .cmd_rw_0(rw0), .cmd_rw_1(rw1),
    .cmd_wdata_0(wd0), .cmd_wdata_1(wd1),
    .rsp_valid_0(rv0[1]), .rsp_valid_1(rv1[1]),
    .rsp_a_0(a0[1]), .rsp_a_1(a1[1]), .rsp_b_0(b0[1]), .rsp_b_1(b1[1]),
    .rf_ra(rfa[1]), .rf_rb(rfb[1]), .rf_rw(rfw[1]), .rf_busw(busw[1]),
    .rf_regwr(regwr[1]), .rf_busa(busa[1]), .rf_busb(busb[1])
  );

  // Register files: registered reads that return the pre-write value, r0 reads 0.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) rfmem[k][i] <= '0;
        busa[k] <= '0;
        busb[k] <= '0;
      end else begin
        busa[k] <= rfmem[k][rfa[k]];
        busb[k] <= rfmem[k][rfb[k]];
        if (regwr[k] && rfw[k] != 5'd0) rfmem[k][rfw[k]] <= busw[k];
      end
    end
  end

  // Reference state per instance: architectural registers, pointers, pending reply.
  int checks = 0;
  int failures = 0;
  int rd_last [2];
  int wr_last [2];
  logic [W-1:0] mmem [2][32];
  bit pv [2];
  int pown [2];
  logic [W-1:0] pa [2];
  logic [W-1:0] pb [2];
  logic [W-1:0] ha [2][2];
  logic [W-1:0] hb [2][2];
  bit acc [2];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    rd_last[k] = 1;
    wr_last[k] = 1;
    pv[k] = 1'b0;
    pown[k] = 0;
    pa[k] = '0;
    pb[k] = '0;
    for (int i = 0; i < 32; i++) mmem[k][i] = '0;
    for (int i = 0; i < 2; i++) begin
      ha[k][i] = '0;
      hb[k][i] = '0;
    end
  endtask

  // Compare instance k against the reference for the current cycle, then advance it.
  task automatic model_step(input int k);
    int rg, wg;
    bit ev;
    logic [4:0] era, erb, erw;
    logic [W-1:0] ewd, aa, ab, avld;
    string t;
    t = (k == 0) ? "rr" : "fp";
    for (int i = 0; i < 2; i++) begin
      ev   = !rst && pv[k] && (pown[k] == i);
      aa   = (i == 0) ? a0[k] : a1[k];
      ab   = (i == 0) ? b0[k] : b1[k];
      avld = (i == 0) ? 32'(rv0[k]) : 32'(rv1[k]);
      chk($sformatf("%s_rsp_valid_%0d", t, i), avld, 32'(ev));
      chk($sformatf("%s_rsp_a_%0d", t, i), aa, ev ? pa[k] : ha[k][i]);
      chk($sformatf("%s_rsp_b_%0d", t, i), ab, ev ? pb[k] : hb[k][i]);
    end
    rg = -1;
    wg = -1;
    if (!rst) begin
      if (v0 && !we0 && v1 && !we1) rg = (k == 0) ? 1 - rd_last[k] : 0;
      else if (v0 && !we0) rg = 0;
      else if (v1 && !we1) rg = 1;
      if (v0 && we0 && v1 && we1) wg = (k == 0) ? 1 - wr_last[k] : 0;
      else if (v0 && we0) wg = 0;
      else if (v1 && we1) wg = 1;
    end
    era = (rg == 0) ? ra0 : (rg == 1) ? ra1 : 5'd0;
    erb = (rg == 0) ? rb0 : (rg == 1) ? rb1 : 5'd0;
    erw = (wg == 0) ? rw0 : (wg == 1) ? rw1 : 5'd0;
    ewd = (wg == 0) ? wd0 : wd1;
    chk($sformatf("%s_ready_0", t), 32'(rdy0[k]), 32'(rg == 0 || wg == 0));
    chk($sformatf("%s_ready_1", t), 32'(rdy1[k]), 32'(rg == 1 || wg == 1));
    chk($sformatf("%s_rf_ra", t), 32'(rfa[k]), 32'(era));
    chk($sformatf("%s_rf_rb", t), 32'(rfb[k]), 32'(erb));
    chk($sformatf("%s_rf_rw", t), 32'(rfw[k]), 32'(erw));
    chk($sformatf("%s_rf_regwr", t), 32'(regwr[k]), 32'(wg >= 0));
    if (wg >= 0) chk($sformatf("%s_rf_busw", t), busw[k], ewd);
    if (k == 0) begin
      acc[0] = (rg == 0) || (wg == 0);
      acc[1] = (rg == 1) || (wg == 1);
    end
    if (rst) begin
      model_reset(k);
    end else begin
      if (pv[k]) begin
        ha[k][pown[k]] = pa[k];
        hb[k][pown[k]] = pb[k];
      end
      // Architectural view: a read sees the write of its own cycle.
      if (wg >= 0 && erw != 5'd0) mmem[k][erw] = ewd;
      pv[k] = (rg >= 0);
      pown[k] = rg;
      if (rg >= 0) begin
        pa[k] = mmem[k][era];
        pb[k] = mmem[k][erb];
        rd_last[k] = rg;
      end
      if (wg >= 0) wr_last[k] = wg;
    end
  endtask

  task automatic apply(input bit r, input cmd_t c0, input cmd_t c1);
    rst = r;
    v0 = c0.v; we0 = c0.we; ra0 = c0.ra; rb0 = c0.rb; rw0 = c0.rw; wd0 = c0.wd;
    v1 = c1.v; we1 = c1.we; ra1 = c1.ra; rb1 = c1.rb; rw1 = c1.rw; wd1 = c1.wd;
  endtask

  function automatic cmd_t rd(input logic [4:0] a, input logic [4:0] b);
    rd = '{1'b1, 1'b0, a, b, 5'd0, 32'd0};
  endfunction

  function automatic cmd_t wr(input logic [4:0] w, input logic [W-1:0] d);
    wr = '{1'b1, 1'b1, 5'd0, 5'd0, w, d};
  endfunction

  function automatic cmd_t idle();
    idle = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0};
  endfunction

  function automatic vec_t mkv(input bit r, input cmd_t c0, input cmd_t c1,
                               input bit er0, input bit er1, input bit ev0, input bit ev1,
                               input logic [W-1:0] ea, input logic [W-1:0] eb,
                               input bit fr0, input bit fr1);
    mkv = '{r, c0, c1, er0, er1, ev0, ev1, ea, eb, fr0, fr1};
  endfunction

  vec_t tbl [23];
  cmd_t rc0, rc1;
  bit rrst;

  initial begin
    // Reset, write-then-read, forwarding, contention, r0 writes, reset mid-read.
    for (int i = 0; i < 3; i++) tbl[i] = mkv(1, rd(1, 2), rd(3, 4), 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mkv(0, rd(1, 2), rd(3, 4), 1, 0, 0, 0, 0, 0, 1, 0);
    tbl[4]  = mkv(0, wr(5, 32'hDEADBEEF), rd(3, 4), 1, 1, 1, 0, 0, 0, 1, 1);
    tbl[5]  = mkv(0, idle(), rd(5, 0), 0, 1, 0, 1, 0, 0, 0, 1);
    tbl[6]  = mkv(0, idle(), idle(), 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0);
    tbl[7]  = mkv(0, wr(7, 32'h12345678), rd(7, 7), 1, 1, 0, 0, 0, 0, 1, 1);
    tbl[8]  = mkv(0, idle(), idle(), 0, 0, 0, 1, 32'h12345678, 32'h12345678, 0, 0);
    tbl[9]  = mkv(0, rd(1, 4), rd(2, 3), 1, 0, 0, 0, 0, 0, 1, 0);
    tbl[10] = mkv(0, rd(1, 4), rd(2, 3), 0, 1, 1, 0, 0, 0, 1, 0);
    tbl[11] = mkv(0, rd(1, 4), rd(2, 3), 1, 0, 0, 1, 0, 0, 1, 0);
    tbl[12] = mkv(0, rd(1, 4), rd(2, 3), 0, 1, 1, 0, 0, 0, 1, 0);
    tbl[13] = mkv(0, idle(), rd(2, 3), 0, 1, 0, 1, 0, 0, 0, 1);
    tbl[14] = mkv(0, idle(), wr(0, 32'hFFFFFFFF), 0, 1, 0, 1, 0, 0, 0, 1);
    tbl[15] = mkv(0, idle(), rd(0, 5), 0, 1, 0, 0, 0, 0, 0, 1);
    tbl[16] = mkv(0, idle(), idle(), 0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0);
    tbl[17] = mkv(0, rd(0, 0), wr(0, 32'hFFFFFFFF), 1, 1, 0, 0, 0, 0, 1, 1);
    tbl[18] = mkv(0, idle(), idle(), 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[19] = mkv(0, idle(), rd(5, 7), 0, 1, 0, 0, 0, 0, 0, 1);
    tbl[20] = mkv(1, idle(), idle(), 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[21] = mkv(0, idle(), rd(5, 7), 0, 1, 0, 0, 0, 0, 0, 1);
    tbl[22] = mkv(0, idle(), idle(), 0, 0, 0, 1, 0, 0, 0, 0);

    model_reset(0);
    model_reset(1);
    apply(1'b1, rd(1, 2), rd(3, 4));
    @(posedge clk);
    #1;

    for (int n = 0; n < 23; n++) begin
      apply(tbl[n].rst, tbl[n].c0, tbl[n].c1);
      @(negedge clk);
      chk($sformatf("vec%0d_ready_0", n), 32'(rdy0[0]), 32'(tbl[n].e_rdy0));
      chk($sformatf("vec%0d_ready_1", n), 32'(rdy1[0]), 32'(tbl[n].e_rdy1));
      chk($sformatf("vec%0d_rsp_valid_0", n), 32'(rv0[0]), 32'(tbl[n].e_rv0));
      chk($sformatf("vec%0d_rsp_valid_1", n), 32'(rv1[0]), 32'(tbl[n].e_rv1));
      chk($sformatf("vec%0d_fp_ready_0", n), 32'(rdy0[1]), 32'(tbl[n].f_rdy0));
      chk($sformatf("vec%0d_fp_ready_1", n), 32'(rdy1[1]), 32'(tbl[n].f_rdy1));
      if (tbl[n].e_rv0) begin
        chk($sformatf("vec%0d_rsp_a_0", n), a0[0], tbl[n].e_a);
        chk($sformatf("vec%0d_rsp_b_0", n), b0[0], tbl[n].e_b);
      end
      if (tbl[n].e_rv1) begin
        chk($sformatf("vec%0d_rsp_a_1", n), a1[0], tbl[n].e_a);
        chk($sformatf("vec%0d_rsp_b_1", n), b1[0], tbl[n].e_b);
      end
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
    end

    // Random traffic; an unaccepted command is held until the RR instance takes it.
    rc0 = idle();
    rc1 = idle();
    acc[0] = 1'b1;
    acc[1] = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      rrst = ($urandom_range(0, 99) == 0);
      if (acc[0] || !rc0.v) begin
        rc0 = '{($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 32'($urandom)};
      end
      if (acc[1] || !rc1.v) begin
        rc1 = '{($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 32'($urandom)};
      end
      apply(rrst, rc0, rc1);
      @(negedge clk);
      model_step(0);
      model_step(1);
      if (rrst) begin
        acc[0] = 1'b1;
        acc[1] = 1'b1;
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
